// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline sequencer: RV32I opcodes, PC-select codes and FSM states.
package pipe_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        PC_PLUS4    = 2'd0,
        PC_REDIRECT = 2'd1,
        PC_HOLD     = 2'd2
    } pc_sel_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DWAIT = 2'd2,
        IWAIT = 2'd3
    } state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Control bundle between the sequencer (master) and the pipeline datapath (slave).
interface pipe_ctrl_if;
    // imem_ready/dmem_ready are single-cycle completions: a high level means the fetch or
    // the EX load/store finished this cycle; low means the pipeline must hold.
    logic [31:0] inst_EX;
    logic        ex_valid;
    logic        br_taken;
    logic        imem_ready;
    logic        dmem_ready;
    logic [1:0]  pc_sel;
    logic        stall_IF;
    logic        flush_EX;
    logic        bubble_WB;

    modport master (
        input  inst_EX, ex_valid, br_taken, imem_ready, dmem_ready,
        output pc_sel, stall_IF, flush_EX, bubble_WB
    );

    modport slave (
        output inst_EX, ex_valid, br_taken, imem_ready, dmem_ready,
        input  pc_sel, stall_IF, flush_EX, bubble_WB
    );
endinterface

// File: rtl/pipe_ctrl_perf_counter.sv
// Free-running event counter: increments on en, wraps naturally, cleared only by reset.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (en)
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: resolves EX control flow, kills wrong-path fetches, holds on memory waits.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    pipe_ctrl_if.master      bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output state_t           state
);

    localparam logic [1:0] KILL_INIT = 2'(FLUSH_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] kill_q, kill_d;
    pc_sel_t    pc_sel_c;
    logic       stall_c, flush_c, bubble_c, flush_inc;
    logic       redirect, mem_op, dwait;
    logic [6:0] opc;

    assign opc      = bus.inst_EX[6:0];
    assign redirect = bus.ex_valid && ((opc == OPC_JAL) || (opc == OPC_JALR) ||
                                       ((opc == OPC_BRANCH) && bus.br_taken));
    assign mem_op   = bus.ex_valid && ((opc == OPC_LOAD) || (opc == OPC_STORE));
    assign dwait    = mem_op && !bus.dmem_ready;

    // Only the opcode field steers the sequencer.
    logic unused_inst;
    assign unused_inst = ^bus.inst_EX[31:7];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            kill_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        kill_d    = kill_q;
        pc_sel_c  = PC_PLUS4;
        stall_c   = 1'b0;
        flush_c   = 1'b0;
        bubble_c  = 1'b0;
        flush_inc = 1'b0;
        case (state_q)
            RUN: begin
                if (dwait) begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                    pc_sel_c = PC_HOLD;
                    state_d  = DWAIT;
                end else if (redirect) begin
                    // A fetch that is still outstanding is absorbed by the kill count.
                    pc_sel_c  = PC_REDIRECT;
                    flush_c   = 1'b1;
                    flush_inc = 1'b1;
                    kill_d    = KILL_INIT;
                    if (FLUSH_CYCLES > 1)
                        state_d = FLUSH;
                end else if (!bus.imem_ready) begin
                    stall_c  = 1'b1;
                    flush_c  = 1'b1;
                    pc_sel_c = PC_HOLD;
                    state_d  = IWAIT;
                end
            end
            FLUSH: begin
                flush_c = 1'b1;
                if (bus.imem_ready) begin
                    flush_inc = 1'b1;
                    kill_d    = kill_q - 2'd1;
                    if (kill_q <= 2'd1) begin
                        kill_d  = 2'd0;
                        state_d = RUN;
                    end
                end else begin
                    stall_c  = 1'b1;
                    pc_sel_c = PC_HOLD;
                end
            end
            DWAIT: begin
                if (bus.dmem_ready) begin
                    state_d = RUN;
                end else begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                    pc_sel_c = PC_HOLD;
                end
            end
            IWAIT: begin
                if (bus.imem_ready) begin
                    state_d = RUN;
                end else begin
                    stall_c  = 1'b1;
                    flush_c  = 1'b1;
                    pc_sel_c = PC_HOLD;
                end
            end
            default: state_d = RUN;
        endcase
        if (reset) begin
            pc_sel_c  = PC_PLUS4;
            stall_c   = 1'b0;
            flush_c   = 1'b0;
            bubble_c  = 1'b0;
            flush_inc = 1'b0;
        end
    end

    assign bus.pc_sel    = pc_sel_c;
    assign bus.stall_IF  = stall_c;
    assign bus.flush_EX  = flush_c;
    assign bus.bubble_WB = bubble_c;
    assign state         = state_q;

    perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    ((state_q == DWAIT) || (state_q == IWAIT)),
        .count (stall_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: one instance with FLUSH_CYCLES=1, one with FLUSH_CYCLES=2.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam logic [31:0] I_JAL  = 32'h0000_00EF;
    localparam logic [31:0] I_JALR = 32'h0000_80E7;
    localparam logic [31:0] I_BEQ  = 32'h0000_0063;
    localparam logic [31:0] I_LW   = 32'h0000_2083;
    localparam logic [31:0] I_SW   = 32'h0010_2023;
    localparam logic [31:0] I_ADD  = 32'h0031_00B3;

    // Output vector layout: {pc_sel[1:0], stall_IF, flush_EX, bubble_WB}
    localparam logic [4:0] O_IDLE  = 5'b00_000;
    localparam logic [4:0] O_REDIR = 5'b01_010;
    localparam logic [4:0] O_DWAIT = 5'b10_101;
    localparam logic [4:0] O_IHOLD = 5'b10_110;
    localparam logic [4:0] O_KILL  = 5'b00_010;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] inst_EX = 32'h0;
    logic        ex_valid = 1'b0;
    logic        br_taken = 1'b0;
    logic        imem_ready = 1'b1;
    logic        dmem_ready = 1'b1;

    logic [31:0] stall_cnt1, flush_cnt1, stall_cnt2, flush_cnt2;
    state_t      state1, state2;
    logic [4:0]  o1, o2;
    int          cmp_n = 0;
    int          fail_n = 0;

    always #5 clk = ~clk;

    pipe_ctrl_if if1 ();
    pipe_ctrl_if if2 ();

    assign if1.inst_EX = inst_EX;      assign if2.inst_EX = inst_EX;
    assign if1.ex_valid = ex_valid;    assign if2.ex_valid = ex_valid;
    assign if1.br_taken = br_taken;    assign if2.br_taken = br_taken;
    assign if1.imem_ready = imem_ready; assign if2.imem_ready = imem_ready;
    assign if1.dmem_ready = dmem_ready; assign if2.dmem_ready = dmem_ready;

    assign o1 = {if1.pc_sel, if1.stall_IF, if1.flush_EX, if1.bubble_WB};
    assign o2 = {if2.pc_sel, if2.stall_IF, if2.flush_EX, if2.bubble_WB};

    pipe_ctrl #(.FLUSH_CYCLES(1), .CNT_W(32)) dut1 (
        .clk(clk), .reset(reset), .bus(if1),
        .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1), .state(state1)
    );

    pipe_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut2 (
        .clk(clk), .reset(reset), .bus(if2),
        .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2), .state(state2)
    );

    // Apply one cycle of inputs at the falling edge; outputs are sampled 1ns later.
    task automatic cyc(input logic v, input logic [31:0] inst, input logic bt,
                       input logic im, input logic dm);
        @(negedge clk);
        ex_valid = v; inst_EX = inst; br_taken = bt; imem_ready = im; dmem_ready = dm;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ex_valid = 1'b0; br_taken = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        cyc(1'b1, I_JAL, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, I_ADD, 1'b0, 1'b1, 1'b1);
        cmp_n++; if (state2 !== FLUSH) begin fail_n++; $display("FAIL rst_pre_flush: got %0d want %0d", state2, FLUSH); end
        cmp_n++; if (flush_cnt2 !== 32'd1) begin fail_n++; $display("FAIL rst_pre_fcnt: got %0d want 1", flush_cnt2); end
        reset = 1'b1;
        #1;
        cmp_n++; if (o2 !== O_IDLE) begin fail_n++; $display("FAIL rst_outs_held: got %b want %b", o2, O_IDLE); end
        @(negedge clk); #1;
        cmp_n++; if (o2 !== O_IDLE) begin fail_n++; $display("FAIL rst_outs_held2: got %b want %b", o2, O_IDLE); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        cmp_n++; if (state2 !== RUN) begin fail_n++; $display("FAIL rst_state: got %0d want %0d", state2, RUN); end
        cmp_n++; if (o2 !== O_IDLE) begin fail_n++; $display("FAIL rst_outs: got %b want %b", o2, O_IDLE); end
        cmp_n++; if (stall_cnt2 !== 32'd0 || flush_cnt2 !== 32'd0) begin
            fail_n++; $display("FAIL rst_cnts: got %0d/%0d want 0/0", stall_cnt2, flush_cnt2);
        end
    endtask

    task automatic test_jal();
        do_reset();
        cyc(1'b1, I_JAL, 1'b0, 1'b1, 1'b1);
        cmp_n++; if (o1 !== O_REDIR) begin fail_n++; $display("FAIL jal_outs: got %b want %b", o1, O_REDIR); end
        cyc(1'b0, I_ADD, 1'b0, 1'b1, 1'b1);
        cmp_n++; if (o1 !== O_IDLE) begin fail_n++; $display("FAIL jal_after: got %b want %b", o1, O_IDLE); end
        cmp_n++; if (state1 !== RUN) begin fail_n++; $display("FAIL jal_state: got %0d want %0d", state1, RUN); end
        cmp_n++; if (flush_cnt1 !== 32'd1) begin fail_n++; $display("FAIL jal_fcnt: got %0d want 1", flush_cnt1); end
    endtask

    task automatic test_branch();
        int flush_hi = 0;
        int stall_hi = 0;
        do_reset();
        cyc(1'b1, I_BEQ, 1'b0, 1'b1, 1'b1);
        cmp_n++; if (o2 !== O_IDLE) begin fail_n++; $display("FAIL beq_nt: got %b want %b", o2, O_IDLE); end
        cyc(1'b1, I_BEQ, 1'b1, 1'b1, 1'b1);
        cmp_n++; if (o2 !== O_REDIR) begin fail_n++; $display("FAIL beq_t: got %b want %b", o2, O_REDIR); end
        flush_hi += int'(if2.flush_EX); stall_hi += int'(if2.stall_IF);
        cyc(1'b0, I_ADD, 1'b0, 1'b0, 1'b1);
        cmp_n++; if (o2 !== O_IHOLD) begin fail_n++; $display("FAIL beq_kill_wait: got %b want %b", o2, O_IHOLD); end
        flush_hi += int'(if2.flush_EX); stall_hi += int'(if2.stall_IF);
        cyc(1'b0, I_ADD, 1'b0, 1'b1, 1'b1);
        cmp_n++; if (o2 !== O_KILL) begin fail_n++; $display("FAIL beq_kill: got %b want %b", o2, O_KILL); end
        flush_hi += int'(if2.flush_EX); stall_hi += int'(if2.stall_IF);
        cyc(1'b0, I_ADD, 1'b0, 1'b1, 1'b1);
        cmp_n++; if (o2 !== O_IDLE) begin fail_n++; $display("FAIL beq_done: got %b want %b", o2, O_IDLE); end
        cmp_n++; if (state2 !== RUN) begin fail_n++; $display("FAIL beq_state: got %0d want %0d", state2, RUN); end
        cmp_n++; if (flush_hi != 3 || stall_hi != 1) begin
            fail_n++; $display("FAIL beq_cycles: got flush %0d stall %0d want 3 1", flush_hi, stall_hi);
        end
        cmp_n++; if (flush_cnt2 !== 32'd2) begin fail_n++; $display("FAIL beq_fcnt: got %0d want 2", flush_cnt2); end
    endtask

    task automatic test_load();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, I_LW, 1'b0, 1'b1, 1'b0);
            cmp_n++; if (o1 !== O_DWAIT) begin fail_n++; $display("FAIL lw_wait%0d: got %b want %b", i, o1, O_DWAIT); end
        end
        cyc(1'b1, I_LW, 1'b0, 1'b1, 1'b1);
        cmp_n++; if (o1 !== O_IDLE) begin fail_n++; $display("FAIL lw_ready: got %b want %b", o1, O_IDLE); end
        cyc(1'b0, I_ADD, 1'b0, 1'b1, 1'b1);
        cmp_n++; if (state1 !== RUN) begin fail_n++; $display("FAIL lw_state: got %0d want %0d", state1, RUN); end
        cmp_n++; if (stall_cnt1 !== 32'd3) begin fail_n++; $display("FAIL lw_scnt: got %0d want 3", stall_cnt1); end
    endtask

    task automatic test_imem_wait();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(i == 0, I_ADD, 1'b0, 1'b0, 1'b1);
            cmp_n++; if (o1 !== O_IHOLD) begin fail_n++; $display("FAIL iw_wait%0d: got %b want %b", i, o1, O_IHOLD); end
        end
        cyc(1'b0, I_ADD, 1'b0, 1'b1, 1'b1);
        cmp_n++; if (o1 !== O_IDLE) begin fail_n++; $display("FAIL iw_ready: got %b want %b", o1, O_IDLE); end
        cyc(1'b0, I_ADD, 1'b0, 1'b1, 1'b1);
        cmp_n++; if (state1 !== RUN) begin fail_n++; $display("FAIL iw_state: got %0d want %0d", state1, RUN); end
        cmp_n++; if (stall_cnt1 !== 32'd4) begin fail_n++; $display("FAIL iw_scnt: got %0d want 4", stall_cnt1); end
    endtask

    task automatic test_decode_edges();
        do_reset();
        cyc(1'b0, I_JALR, 1'b1, 1'b1, 1'b1);
        cmp_n++; if (o1 !== O_IDLE) begin fail_n++; $display("FAIL jalr_inv: got %b want %b", o1, O_IDLE); end
        cyc(1'b1, I_JALR, 1'b0, 1'b0, 1'b1);
        cmp_n++; if (flush_cnt1 !== 32'd0) begin fail_n++; $display("FAIL jalr_inv_fcnt: got %0d want 0", flush_cnt1); end
        cmp_n++; if (o1 !== O_REDIR) begin fail_n++; $display("FAIL jalr_imem_lo: got %b want %b", o1, O_REDIR); end
        cyc(1'b0, I_ADD, 1'b0, 1'b1, 1'b1);
        cmp_n++; if (state1 !== RUN || flush_cnt1 !== 32'd1) begin
            fail_n++; $display("FAIL jalr_after: got state %0d fcnt %0d want 0 1", state1, flush_cnt1);
        end
        cyc(1'b1, I_SW, 1'b0, 1'b1, 1'b0);
        cmp_n++; if (o1 !== O_DWAIT) begin fail_n++; $display("FAIL sw_wait: got %b want %b", o1, O_DWAIT); end
        cyc(1'b0, I_SW, 1'b0, 1'b1, 1'b0);
        cmp_n++; if (o1 !== O_DWAIT || state1 !== DWAIT) begin
            fail_n++; $display("FAIL sw_hold: got %b st %0d want %b st %0d", o1, state1, O_DWAIT, DWAIT);
        end
        cyc(1'b1, I_SW, 1'b0, 1'b1, 1'b1);
        cmp_n++; if (o1 !== O_IDLE) begin fail_n++; $display("FAIL sw_ready: got %b want %b", o1, O_IDLE); end
    endtask

    initial begin
        test_reset();
        test_jal();
        test_branch();
        test_load();
        test_imem_wait();
        test_decode_edges();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
        $finish;
    end

endmodule
